flat_resp_capture: RTL and testbench

Response-capture stage that sits directly downstream of the flattened logic-module wrapper in the fuzz harness. Each beat carries the 8-bit stimulus vector (`in_flat`) and the 6-bit response (`out_flat`) from the device under test. The block counts a programmed number of beats and compacts them into a 16-bit MISR signature. It also buffers the raw beats in a small FIFO so the host can read them out with a valid/ready handshake.

---
 rtl/flat_resp_capture.sv | 137 +++++++++++++
 tb/tb_flat_resp_capture.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/flat_resp_capture.sv
// flat_resp_capture: counts a programmed number of {stimulus, response} beats,
//   compacts them into a MISR signature, and buffers the raw beats in a FWFT FIFO.
// Latency: an accepted beat shows in signature/vec_count and, if the FIFO was empty,
//   on m_data one cycle later. Throughput is one beat per cycle in each direction.
// Backpressure: s_ready drops while the FIFO is full or outside RUN, so upstream holds
//   the beat. m_valid/m_ready drain the FIFO in every state.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   start, num_vecs       one-cycle run start; beat count latched on start
//   s_valid/s_ready       input beat handshake, beat = {s_in, s_out}
//   m_valid/m_ready       FIFO head handshake, head on m_data (0 when empty)
//   signature, vec_count  running MISR value and beats accepted this run
//   busy, done            RUN/DRAIN and DONE status
module flat_resp_capture #(
  parameter int              IN_W  = 8,
  parameter int              OUT_W = 6,
  parameter int              DEPTH = 8,
  parameter int              SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY = 16'h1021,
  parameter logic [SIG_W-1:0] SEED = 16'hFFFF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [15:0]            num_vecs,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [IN_W-1:0]        s_in,
  input  logic [OUT_W-1:0]       s_out,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [IN_W+OUT_W-1:0]  m_data,
  output logic [SIG_W-1:0]       signature,
  output logic [15:0]            vec_count,
  output logic                   busy,
  output logic                   done
);

  localparam int D_W = IN_W + OUT_W;
  localparam int AW  = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [15:0]      num_q, num_d;
  // Pointers carry one extra bit so that full and empty are distinguishable.
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [D_W-1:0]   mem_q [DEPTH];
  logic [D_W-1:0]   mem_d [DEPTH];

  logic             empty, full, push, pop;
  logic [D_W-1:0]   beat;
  logic [SIG_W-1:0] beat_ext;

  always_comb begin
    empty    = (wr_q == rd_q);
    full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    beat     = {s_in, s_out};
    beat_ext = '0;
    beat_ext[D_W-1:0] = beat;
    push     = s_valid && (state_q == RUN) && !full;
    pop      = !empty && m_ready;
  end

  assign s_ready   = (state_q == RUN) && !full;
  assign m_valid   = !empty;
  assign m_data    = empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign signature = sig_q;
  assign vec_count = cnt_q;
  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    mem_d   = mem_q;

    case (state_q)
      IDLE, DONE: begin
        // FIFO contents survive a new start; only the run counters reseed.
        if (start) begin
          sig_d   = SEED;
          cnt_d   = '0;
          num_d   = num_vecs;
          state_d = (num_vecs == 16'd0) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (push) begin
          cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
          sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ beat_ext;
          if (cnt_d == num_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Uses the pre-edge empty flag, so the last pop costs one extra cycle.
        if (empty) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    if (push) begin
      mem_d[wr_q[AW-1:0]] = beat;
      wr_d = wr_q + (AW+1)'(1);
    end
    if (pop) rd_d = rd_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sig_q   <= '0;
      cnt_q   <= '0;
      num_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: tb/tb_flat_resp_capture.sv
// tb_flat_resp_capture: directed bench for flat_resp_capture with default parameters.
module tb_flat_resp_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] num_vecs;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_in;
  logic [5:0]  s_out;
  logic        m_valid;
  logic        m_ready;
  logic [13:0] m_data;
  logic [15:0] signature;
  logic [15:0] vec_count;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  int          acc_n, pop_n, tgt, off;
  bit          feed;
  logic [15:0] sig_m;
  logic [15:0] golden;

  flat_resp_capture dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_vecs(num_vecs),
    .s_valid(s_valid), .s_ready(s_ready), .s_in(s_in), .s_out(s_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .signature(signature), .vec_count(vec_count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // MISR step as written in the block description.
  function automatic logic [15:0] misr(input logic [15:0] s, input logic [13:0] b);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {2'b00, b};
  endfunction

  function automatic logic [13:0] beat(input int k);
    logic [7:0] a;
    logic [5:0] r;
    a = 8'(k * 19 + 16);
    r = 6'(k * 5 + 1);
    return {a, r};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat();
    s_valid = feed && (acc_n < tgt);
    {s_in, s_out} = beat(off + acc_n);
  endtask

  // One clock: check any pop against the expected order, update the model on accept.
  task automatic cycle();
    bit a, p;
    a = s_valid && s_ready;
    p = m_valid && m_ready;
    if (p) check("pop_data", 32'(m_data), 32'(beat(off + pop_n)));
    step();
    if (a) begin
      sig_m = misr(sig_m, beat(off + acc_n));
      acc_n++;
    end
    if (p) pop_n++;
    drive_beat();
  endtask

  task automatic start_run(input int n, input int o);
    tgt = n; off = o; acc_n = 0; pop_n = 0; sig_m = 16'hFFFF; feed = 1'b1;
    s_valid = 1'b0;
    start = 1'b1;
    num_vecs = 16'(n);
    step();
    start = 1'b0;
    drive_beat();
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done; i++) cycle();
    check("done_reached", 32'(done), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; num_vecs = '0; s_valid = 1'b0;
    s_in = '0; s_out = '0; m_ready = 1'b0; feed = 1'b0;
    acc_n = 0; pop_n = 0; tgt = 0; off = 0; sig_m = '0;

    // Reset: all outputs zero during and after reset.
    step(); step();
    check("rst_outputs", {s_ready, m_valid, busy, done, m_data, signature}, 32'd0);
    check("rst_count", 32'(vec_count), 32'd0);
    rst_n = 1'b1;
    step();
    check("idle_outputs", {s_ready, m_valid, busy, done, m_data, signature}, 32'd0);

    // Single vector A5/2A.
    start = 1'b1; num_vecs = 16'd1;
    step();
    start = 1'b0;
    check("sv_busy", 32'(busy), 32'd1);
    check("sv_seed", 32'(signature), 32'hFFFF);
    check("sv_ready", 32'(s_ready), 32'd1);
    s_valid = 1'b1; s_in = 8'hA5; s_out = 6'h2A;
    step();
    s_valid = 1'b0;
    check("sv_sig", 32'(signature), 32'hC6B5);
    check("sv_cnt", 32'(vec_count), 32'd1);
    check("sv_mvalid", 32'(m_valid), 32'd1);
    check("sv_mdata", 32'(m_data), 32'h296A);
    check("sv_drain_ready", 32'(s_ready), 32'd0);
    m_ready = 1'b1;
    step();
    check("sv_popped", 32'(m_valid), 32'd0);
    check("sv_not_done_yet", 32'(done), 32'd0);
    step();
    check("sv_done", {busy, done}, 32'd1);
    check("sv_sig_hold", 32'(signature), 32'hC6B5);
    m_ready = 1'b0;

    // Zero-length run.
    start = 1'b1; num_vecs = 16'd0;
    step();
    start = 1'b0;
    check("zl_drain", {busy, done, s_ready}, 32'b100);
    check("zl_seed", 32'(signature), 32'hFFFF);
    step();
    check("zl_done", {busy, done, s_ready}, 32'b010);
    check("zl_cnt", 32'(vec_count), 32'd0);
    check("zl_sig", 32'(signature), 32'hFFFF);

    // Backpressure: 10 beats into an 8-entry FIFO with the host stalled.
    m_ready = 1'b0;
    start_run(10, 0);
    for (int i = 0; i < 12; i++) cycle();
    check("bp_accepted", 32'(acc_n), 32'd8);
    check("bp_cnt", 32'(vec_count), 32'd8);
    check("bp_full_ready", 32'(s_ready), 32'd0);
    check("bp_head", 32'(m_data), 32'(beat(0)));
    m_ready = 1'b1;
    wait_done(60);
    check("bp_pops", 32'(pop_n), 32'd10);
    check("bp_cnt_final", 32'(vec_count), 32'd10);
    check("bp_sig", 32'(signature), 32'(sig_m));

    // Start pulse ignored mid-run.
    start_run(5, 40);
    while (acc_n < 3) cycle();
    start = 1'b1;
    num_vecs = 16'd1;
    cycle();
    start = 1'b0;
    check("si_busy", 32'(busy), 32'd1);
    check("si_cnt", 32'(vec_count), 32'(acc_n));
    check("si_sig", 32'(signature), 32'(sig_m));
    wait_done(40);
    check("si_cnt_final", 32'(vec_count), 32'd5);
    check("si_sig_final", 32'(signature), 32'(sig_m));

    // Reset with 4 beats buffered.
    m_ready = 1'b0;
    start_run(6, 20);
    for (int i = 0; i < 4; i++) cycle();
    check("mr_cnt", 32'(vec_count), 32'd4);
    check("mr_mvalid", 32'(m_valid), 32'd1);
    rst_n = 1'b0;
    feed = 1'b0;
    s_valid = 1'b0;
    #1;
    check("mr_async", {m_valid, busy, done, s_ready}, 32'd0);
    check("mr_sig", 32'(signature), 32'd0);
    check("mr_vc", 32'(vec_count), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    m_ready = 1'b1;
    golden = 16'hFFFF;
    for (int k = 20; k < 26; k++) golden = misr(golden, beat(k));
    start_run(6, 20);
    wait_done(60);
    check("mr_pops", 32'(pop_n), 32'd6);
    check("mr_golden", 32'(signature), 32'(golden));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule
